uart_link: RTL and testbench

- Full-duplex 8N1 UART block: a transmit path serializes a byte onto TX, and an independent receive path deserializes RX into a byte.
- Sits between the design's command/telemetry logic and the serial pins.
- Transmit and receive share clock, reset and baud parameter only; there is no internal loopback, so benches connect TX to RX externally.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_path.sv | 94 +++++++++
 rtl/uart_link.sv | 93 +++++++++
 tb/tb_uart_link.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state types for the uart_link block.
//   BAUD_CYCLES_DEFAULT - clock cycles per bit at 50 MHz / 19200 baud
//   FRAME_BITS          - 8N1 frame length in bit periods (start + 8 data + stop)
//   tx_state_t, rx_state_t - transmit / receive FSM states
package uart_pkg;

    localparam int unsigned BAUD_CYCLES_DEFAULT = 2604;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

endpackage

// File: rtl/uart_rx_path.sv
// uart_rx_path: 8N1 receive path. Synchronizes RX, detects the start bit, samples
// each bit at mid-period and presents the byte with a sticky ready flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   RX         - asynchronous serial input, idle high
//   clr_rdy    - clears rdy (a simultaneous set wins)
//   rx_data    - last received byte
//   rdy        - byte available
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam int unsigned CW = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    rx_state_t       rx_state_q;
    logic            rx_meta_q;
    logic            rx_sync_q;
    logic [CW-1:0]   rx_baud_q;
    logic [3:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic [7:0]      rx_data_q;
    logic            rdy_q;

    // Two-flop synchronizer, preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Baud counter counts down; a sample is taken when it reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy_q <= 1'b0;
            end
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= RX_RECV;
                        rdy_q      <= 1'b0;
                        rx_baud_q  <= HALF_LAST;
                        rx_bit_q   <= '0;
                    end
                end
                RX_RECV: begin
                    if (rx_baud_q == '0) begin
                        rx_baud_q <= BAUD_LAST;
                        if (rx_bit_q == BIT_LAST) begin
                            // Stop sample: start bit has already fallen out of the
                            // shifter, which now holds exactly the data byte.
                            rx_data_q  <= rx_shift_q;
                            rdy_q      <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                            rx_bit_q   <= rx_bit_q + 4'd1;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q - CNT_ONE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/uart_link.sv
// uart_link: full-duplex 8N1 UART. Transmit path is inline; receive path lives
// in uart_rx_path. No internal loopback.
//   clk, rst_n - clock, asynchronous active-low reset
//   trmt       - one-cycle pulse: start sending tx_data (ignored while busy)
//   tx_data    - byte to send, sampled on the accepted trmt cycle
//   TX         - serial output, idle high
//   tx_done    - frame sent; held until the next accepted trmt
//   RX         - serial input, idle high
//   clr_rdy    - clears rdy
//   rx_data    - last received byte
//   rdy        - byte available
module uart_link
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam int unsigned CW = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    tx_state_t       tx_state_q;
    logic [9:0]      tx_shift_q;
    logic [CW-1:0]   tx_baud_q;
    logic [3:0]      tx_bit_q;
    logic            tx_done_q;

    // Shifter resets to all ones so TX idles high, including asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift_q <= {1'b1, tx_data, 1'b0};
                        tx_done_q  <= 1'b0;
                        tx_baud_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_baud_q == BAUD_LAST) begin
                        tx_baud_q  <= '0;
                        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                        if (tx_bit_q == BIT_LAST) begin
                            tx_bit_q   <= '0;
                            tx_done_q  <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + CNT_ONE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

    uart_rx_path #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) u_rx_path (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
    );

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: self-checking bench for uart_link with BAUD_CYCLES=16.
// A frame-level model predicts TX and tx_done every cycle; a byte scoreboard
// checks rx_data whenever rdy rises.
module tb_uart_link;

    localparam int unsigned BAUD  = 16;
    localparam int          FRAME = 160;
    localparam int          LIMIT = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       clr_rdy = 1'b0;
    logic       loop_en = 1'b1;
    logic       rx_drv = 1'b1;
    logic       rx_line;
    logic       TX;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rdy;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    assign rx_line = loop_en ? TX : rx_drv;

    uart_link #(
        .BAUD_CYCLES(BAUD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .RX      (rx_line),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transmitted frame is just the 10-bit word {stop, data, start} held for
    // BAUD cycles per bit, starting the cycle after an accepted trmt.
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    logic [9:0] m_frame = '1;
    logic       m_done = 1'b0;
    logic [7:0] rxq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_cnt   = 0;
            m_frame = '1;
            m_done  = 1'b0;
            rxq.delete();
        end else if (!m_busy) begin
            if (trmt) begin
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_frame = {1'b1, tx_data, 1'b0};
                m_done  = 1'b0;
                if (loop_en) rxq.push_back(tx_data);
            end
        end else begin
            m_cnt++;
            if (m_cnt == FRAME) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    function automatic logic exp_tx();
        return m_busy ? m_frame[m_cnt / BAUD] : 1'b1;
    endfunction

    // ---------------- compare process ----------------
    logic       rdy_prev = 1'b0;
    logic [7:0] rxd_prev = 8'h00;

    always @(negedge clk) begin
        chk("tx_line", {31'd0, TX}, {31'd0, exp_tx()});
        chk("tx_done", {31'd0, tx_done}, {31'd0, m_done});
        if (!rst_n) begin
            chk("reset_rdy", {31'd0, rdy}, 32'd0);
            chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        end else if (rdy && !rdy_prev) begin
            if (rxq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdy_unexpected actual=rdy rise required=no byte pending (t=%0t)",
                         $time);
            end else begin
                chk("rx_byte", {24'd0, rx_data}, {24'd0, rxq.pop_front()});
            end
        end else begin
            chk("rx_data_hold", {24'd0, rx_data}, {24'd0, rxd_prev});
        end
        rdy_prev = rdy;
        rxd_prev = rx_data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle index of the trmt accept edge.
    task automatic launch(input logic [7:0] b, output int t0);
        trmt    = 1'b1;
        tx_data = b;
        tick();
        t0      = cycle;
        trmt    = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_done(input int t0, output int len);
        while (!tx_done && (cycle - t0) < LIMIT) tick();
        len = cycle - t0;
    endtask

    initial begin
        int         t0;
        int         len;
        int         n;
        logic       seen;
        logic       v;
        logic [9:0] word;
        logic [7:0] b;

        // Reset state
        repeat (3) tick();
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // First byte 55: start bit right after the accept edge, full loopback
        launch(8'h55, t0);
        chk("start_bit", {31'd0, TX}, 32'd0);
        wait_done(t0, len);
        chk("len_55", len, FRAME);
        chk("rdy_55", {31'd0, rdy}, 32'd1);
        chk("rx_data_55", {24'd0, rx_data}, 32'h55);
        chk("tx_idle_55", {31'd0, TX}, 32'd1);

        // Back-to-back F0 then 0F
        launch(8'hF0, t0);
        chk("done_drop_f0", {31'd0, tx_done}, 32'd0);
        repeat (4) tick();
        chk("rdy_drop_f0", {31'd0, rdy}, 32'd0);
        wait_done(t0, len);
        chk("len_f0", len, FRAME);
        chk("rx_data_f0", {24'd0, rx_data}, 32'hF0);
        launch(8'h0F, t0);
        chk("done_drop_0f", {31'd0, tx_done}, 32'd0);
        repeat (4) tick();
        chk("rdy_drop_0f", {31'd0, rdy}, 32'd0);
        wait_done(t0, len);
        chk("len_0f", len, FRAME);
        chk("rx_data_0f", {24'd0, rx_data}, 32'h0F);

        // trmt re-pulsed mid-frame with other data is ignored
        launch(8'hC3, t0);
        repeat (50) tick();
        trmt    = 1'b1;
        tx_data = 8'h3A;
        tick();
        trmt    = 1'b0;
        wait_done(t0, len);
        chk("len_repulse", len, FRAME);
        chk("rx_data_c3", {24'd0, rx_data}, 32'hC3);

        // clr_rdy clears the flag, data stays
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
        chk("clr_rdy", {31'd0, rdy}, 32'd0);
        chk("clr_keeps_data", {24'd0, rx_data}, 32'hC3);

        // clr_rdy held through the set cycle: set must still win
        clr_rdy = 1'b1;
        launch(8'h5A, t0);
        seen = 1'b0;
        while (!tx_done && (cycle - t0) < LIMIT) begin
            tick();
            if (rdy) seen = 1'b1;
        end
        clr_rdy = 1'b0;
        chk("set_wins", {31'd0, seen}, 32'd1);
        chk("rx_data_5a", {24'd0, rx_data}, 32'h5A);

        // Reset mid-frame of A5
        launch(8'hA5, t0);
        repeat (70) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, TX}, 32'd1);
        chk("midrst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("midrst_rdy", {31'd0, rdy}, 32'd0);
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        launch(8'h3C, t0);
        wait_done(t0, len);
        chk("len_3c", len, FRAME);
        chk("rx_data_3c", {24'd0, rx_data}, 32'h3C);

        // RX driven directly with 81; each data bit is correct only near mid-bit
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        tick();
        rxq.push_back(8'h81);
        word = {1'b1, 8'h81, 1'b0};
        for (int t = 0; t < FRAME; t++) begin
            v = word[t / BAUD];
            if ((t / BAUD) >= 1 && (t / BAUD) <= 8 && ((t % BAUD) < 6 || (t % BAUD) > 10))
                v = ~v;
            rx_drv = v;
            tick();
        end
        rx_drv = 1'b1;
        n = 0;
        while (!rdy && n < 40) begin
            tick();
            n++;
        end
        chk("rdy_81", {31'd0, rdy}, 32'd1);
        chk("rx_data_81", {24'd0, rx_data}, 32'h81);
        repeat (4) tick();
        loop_en = 1'b1;
        repeat (2) tick();

        // Randomized frames: random gaps, stray trmt pulses, tx_data churn, clr_rdy
        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, 15);
            for (int g = 0; g < n; g++) begin
                clr_rdy = ($urandom_range(0, 3) == 0);
                tick();
            end
            clr_rdy = 1'b0;
            b = 8'($urandom);
            launch(b, t0);
            while (!tx_done && (cycle - t0) < LIMIT) begin
                trmt    = ($urandom_range(0, 19) == 0);
                tx_data = 8'($urandom);
                clr_rdy = ($urandom_range(0, 29) == 0);
                tick();
            end
            trmt    = 1'b0;
            clr_rdy = 1'b0;
            chk("len_random", cycle - t0, FRAME);
        end

        repeat (5) tick();
        chk("scoreboard_empty", rxq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
